rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL provide parameter STARVE_LIMIT, default 3: consecutive ALU wait cycles after which the ALU wins arbitration.
REQ-002 SHALL have clk input 1: rising-edge clock.
REQ-003 SHALL have reset input 1: synchronous, active-high.
REQ-004 SHALL have rf_hold input 1: register file unavailable (preload in progress); no grants while high.
REQ-005 SHALL have alu_valid input 1, alu_rd input 5, alu_data input 32: ALU writeback request (full-word write).
REQ-006 SHALL have alu_ready output 1: ALU request accepted this cycle.
REQ-007 SHALL have ld_valid input 1, ld_rd input 5, ld_data input 32, ld_type input 3: load writeback request; ld_type uses write codes 1=word, 2=lh, 3=lb, 4=lhu, 5=lbu.
REQ-008 SHALL have ld_ready output 1: load request accepted this cycle.
REQ-009 SHALL have rf_rwe output 3, rf_addr_d output 5, rf_data_d output 32: registered register-file write port (0 = no write).
REQ-010 SHALL have err_type output 1: sticky illegal ld_type flag.

Function
REQ-011 SHALL accept a request only when valid and ready are both high in the same cycle; ready is combinational from valid, rf_hold and the starvation count.
REQ-012 SHALL hold ready low for both requesters while rf_hold=1; starvation count still advances if alu_valid=1.
REQ-013 SHALL grant at most one requester per cycle.
REQ-014 SHALL grant the load by default when both are valid; SHALL grant the ALU instead when starve_cnt == STARVE_LIMIT.
REQ-015 SHALL grant the sole valid requester when only one is valid and rf_hold=0.
REQ-016 SHALL increment starve_cnt, saturating at STARVE_LIMIT, each cycle alu_valid=1 and alu_ready=0; SHALL clear it when the ALU is granted or alu_valid=0.
REQ-017 SHALL drive the accepted request on rf_rwe/rf_addr_d/rf_data_d on the following cycle, for exactly one cycle: latency 1.
REQ-018 SHALL drive rf_rwe=1 for an accepted ALU request and rf_rwe=ld_type for an accepted load.
REQ-019 SHALL drive rf_rwe=0, rf_addr_d=0, rf_data_d=0 in any cycle after no grant.
REQ-020 SHALL accept requests with rd=0 (ready behaves normally) but emit rf_rwe=0 for them.
REQ-021 SHALL accept a load with ld_type 0, 6 or 7, emit rf_rwe=0, and set err_type=1 until reset.
REQ-022 SHALL treat same-rd simultaneous requests like any other conflict; the loser is written in a later cycle, so the later write wins.
REQ-023 SHALL require requesters to hold rd/data/type stable while valid=1 and ready=0; behaviour otherwise is undefined.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, clear starve_cnt, rf_rwe, rf_addr_d, rf_data_d and err_type to 0.
REQ-025 SHALL hold alu_ready=0 and ld_ready=0 combinationally while reset=1.
REQ-026 SHALL drop any in-flight write on a mid-operation reset; rf_rwe=0 on the cycle after the reset edge.

Structure
REQ-027 SHALL place the write codes (NONE=0, WORD=1, LH=2, LB=3, LHU=4, LBU=5) as constants in shared package rf_wb_pkg, for use by the register file and the load unit.
REQ-028 SHALL be a single module with no sub-module; the arbiter, starvation counter and output register are inline.

Verification
REQ-029 Both valid (alu_rd=5, alu_data=0x11111111; ld_rd=6, ld_data=0x0000ABCD, ld_type=4) -> ld_ready=1; next cycle rf_rwe=4, rf_addr_d=6, rf_data_d=0x0000ABCD.
REQ-030 alu_valid=1 and ld_valid=1 continuously with distinct loads, STARVE_LIMIT=3 -> loads granted 3 cycles, ALU granted on 4th; rf_rwe=1, rf_addr_d=5, rf_data_d=0x11111111 on 5th.
REQ-031 rf_hold=1 for 4 cycles with alu_valid=1 -> no ready and rf_rwe=0 throughout; first grant the cycle rf_hold falls.
REQ-032 ALU request rd=0, data=0xDEADBEEF -> alu_ready=1; next cycle rf_rwe=0.
REQ-033 Load with ld_type=6 -> ld_ready=1; rf_rwe=0 next cycle; err_type=1 persists until reset.
REQ-034 Reset asserted the cycle a load is granted -> rf_rwe=0 the following cycle; starve_cnt and err_type=0.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: register-file write codes shared by the writeback arbiter, register file and load unit
package rf_wb_pkg;

    typedef enum logic [2:0] {
        WR_NONE = 3'd0,
        WR_WORD = 3'd1,
        WR_LH   = 3'd2,
        WR_LB   = 3'd3,
        WR_LHU  = 3'd4,
        WR_LBU  = 3'd5
    } wr_code_e;

    typedef logic [2:0] wr_t;

    function automatic logic legal_ld_type(input wr_t t);
        return t inside {WR_WORD, WR_LH, WR_LB, WR_LHU, WR_LBU};
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: ALU/load writeback requests and the registered register-file write port
interface rf_wb_arbiter_if;
    import rf_wb_pkg::*;

    logic        rf_hold;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    wr_t         ld_type;
    logic        ld_ready;
    wr_t         rf_rwe;
    logic [4:0]  rf_addr_d;
    logic [31:0] rf_data_d;
    logic        err_type;

    modport master (
        output rf_hold, alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ld_type,
        input  alu_ready, ld_ready, rf_rwe, rf_addr_d, rf_data_d, err_type
    );

    modport slave (
        input  rf_hold, alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ld_type,
        output alu_ready, ld_ready, rf_rwe, rf_addr_d, rf_data_d, err_type
    );

endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: load-priority writeback arbiter with ALU anti-starvation and a one-cycle write port
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input logic clk,
    input logic reset,
    rf_wb_arbiter_if.slave bus
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          starved;
    logic          alu_go;
    logic          ld_go;
    logic          ld_legal;

    // Loads win by default; a starved ALU takes the slot. Nothing is granted during hold or reset.
    always_comb begin
        starved  = starve_cnt == LIM;
        ld_legal = legal_ld_type(bus.ld_type);
        alu_go   = !reset && !bus.rf_hold && bus.alu_valid && (!bus.ld_valid || starved);
        ld_go    = !reset && !bus.rf_hold && bus.ld_valid && !(bus.alu_valid && starved);
    end

    assign bus.alu_ready = alu_go;
    assign bus.ld_ready  = ld_go;

    // Count consecutive cycles the ALU waits, saturating; any ALU grant or idle ALU clears it.
    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (bus.alu_valid && !alu_go)
            starve_cnt <= starved ? starve_cnt : starve_cnt + CW'(1);
        else
            starve_cnt <= '0;
    end

    // Register the accepted request for one cycle; rd=0 and illegal load types are suppressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rf_rwe    <= WR_NONE;
            bus.rf_addr_d <= '0;
            bus.rf_data_d <= '0;
        end else if (alu_go) begin
            bus.rf_rwe    <= (bus.alu_rd == 5'd0) ? WR_NONE : WR_WORD;
            bus.rf_addr_d <= bus.alu_rd;
            bus.rf_data_d <= bus.alu_data;
        end else if (ld_go) begin
            bus.rf_rwe    <= (bus.ld_rd == 5'd0 || !ld_legal) ? wr_t'(WR_NONE) : bus.ld_type;
            bus.rf_addr_d <= bus.ld_rd;
            bus.rf_data_d <= bus.ld_data;
        end else begin
            bus.rf_rwe    <= WR_NONE;
            bus.rf_addr_d <= '0;
            bus.rf_data_d <= '0;
        end
    end

    // Sticky flag for any accepted load carrying an undefined write code.
    always_ff @(posedge clk) begin
        if (reset)
            bus.err_type <= 1'b0;
        else if (ld_go && !ld_legal)
            bus.err_type <= 1'b1;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus constrained-random traffic against a behavioural model
module tb_rf_wb_arbiter;

    localparam int LIM = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial forever #5 clk = ~clk;

    bit          rst, hold, av, lv;
    logic [4:0]  ard, lrd;
    logic [31:0] adat, ldat;
    logic [2:0]  lt;

    int          wait_cnt = 0;
    logic [2:0]  m_rwe = 0;
    logic [4:0]  m_addr = 0;
    logic [31:0] m_data = 0;
    bit          m_err = 0;
    int          last_win = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        int win;
        @(negedge clk);
        reset         = rst;
        bus.rf_hold   = hold;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = adat;
        bus.ld_valid  = lv;
        bus.ld_rd     = lrd;
        bus.ld_data   = ldat;
        bus.ld_type   = lt;
        #1;
        win = 0;
        if (!rst && !hold) begin
            if (av && lv) win = (wait_cnt >= LIM) ? 1 : 2;
            else if (av) win = 1;
            else if (lv) win = 2;
        end
        chk("alu_ready", 32'(bus.alu_ready), 32'(win == 1));
        chk("ld_ready", 32'(bus.ld_ready), 32'(win == 2));
        chk("rf_rwe", 32'(bus.rf_rwe), 32'(m_rwe));
        chk("rf_addr_d", 32'(bus.rf_addr_d), 32'(m_addr));
        chk("rf_data_d", bus.rf_data_d, m_data);
        chk("err_type", 32'(bus.err_type), 32'(m_err));
        last_win = win;
        if (rst) begin
            wait_cnt = 0;
            m_err = 0;
        end else if (av && win != 1) begin
            wait_cnt = (wait_cnt + 1 > LIM) ? LIM : wait_cnt + 1;
        end else begin
            wait_cnt = 0;
        end
        m_rwe = 0;
        m_addr = 0;
        m_data = 0;
        if (win == 1) begin
            m_rwe = (ard == 0) ? 3'd0 : 3'd1;
            m_addr = ard;
            m_data = adat;
        end else if (win == 2) begin
            m_rwe = (lrd == 0 || lt == 0 || lt > 5) ? 3'd0 : lt;
            m_addr = lrd;
            m_data = ldat;
            if (lt == 0 || lt > 5) m_err = 1;
        end
    endtask

    task automatic idle();
        av = 0;
        lv = 0;
        hold = 0;
        rst = 0;
    endtask

    initial begin
        rst = 1; hold = 0; av = 0; lv = 0;
        ard = 0; adat = 0; lrd = 0; ldat = 0; lt = 0;
        reset = 1;
        bus.rf_hold = 0; bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0; bus.ld_type = 0;
        step();
        step();
        idle();
        step();

        av = 1; ard = 5; adat = 32'h11111111;
        lv = 1; lrd = 6; ldat = 32'h0000ABCD; lt = 4;
        step();
        idle();
        step();
        chk("both_valid_rwe", 32'(bus.rf_rwe), 32'd4);
        chk("both_valid_addr", 32'(bus.rf_addr_d), 32'd6);

        av = 1; ard = 5; adat = 32'h11111111; lt = 1;
        for (int i = 0; i < 4; i++) begin
            lv = 1; lrd = 5'(10 + i); ldat = 32'(i + 100);
            step();
        end
        idle();
        step();
        chk("starve_rwe", 32'(bus.rf_rwe), 32'd1);
        chk("starve_data", bus.rf_data_d, 32'h11111111);

        hold = 1; av = 1; ard = 9; adat = 32'h12345678;
        for (int i = 0; i < 4; i++) step();
        hold = 0;
        step();
        chk("hold_release_ready", 32'(last_win), 32'd1);
        idle();
        step();

        av = 1; ard = 0; adat = 32'hDEADBEEF;
        step();
        idle();
        step();
        chk("rd0_rwe", 32'(bus.rf_rwe), 32'd0);

        lv = 1; lrd = 7; ldat = 32'hCAFEF00D; lt = 6;
        step();
        idle();
        for (int i = 0; i < 3; i++) step();
        chk("err_sticky", 32'(bus.err_type), 32'd1);

        lv = 1; lrd = 8; ldat = 32'h55; lt = 1; rst = 1;
        step();
        idle();
        step();
        chk("reset_drop_rwe", 32'(bus.rf_rwe), 32'd0);
        chk("reset_err", 32'(bus.err_type), 32'd0);

        for (int i = 0; i < 2000; i++) begin
            rst  = ($urandom_range(99) == 0);
            hold = ($urandom_range(7) == 0);
            if (!(av && last_win != 1) || rst) begin
                av = $urandom_range(1);
                ard = 5'($urandom_range(31));
                adat = $urandom;
            end
            if (!(lv && last_win != 2) || rst) begin
                lv = $urandom_range(1);
                lrd = 5'($urandom_range(31));
                ldat = $urandom;
                lt = ($urandom_range(9) == 0) ? 3'(($urandom_range(2) == 0) ? 0 : $urandom_range(7, 6))
                                              : 3'($urandom_range(5, 1));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
